// File: rtl/clk_divider_multi.sv
// clk_divider_multi: NUM_CH independent, run-time programmable square-wave
// dividers with glitch-free divisor updates (applied at toggle boundaries).
// Optional feature macro: CLK_DIV_TICK_EN adds a per-channel 'tick' output that
// pulses for one clk_in cycle on every divided_clk toggle.
module clk_divider_multi #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 26,
  parameter int DEFAULT_HALF = 40000000,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic [NUM_CH-1:0] cfg_pending,
  output logic [NUM_CH-1:0] divided_clk
`ifdef CLK_DIV_TICK_EN
  ,
  output logic [NUM_CH-1:0] tick
`endif
);

  localparam logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEFAULT_HALF);

  logic [NUM_CH-1:0][CNT_W-1:0] r_cnt;
  logic [NUM_CH-1:0][CNT_W-1:0] r_half_act;
  logic [NUM_CH-1:0][CNT_W-1:0] r_half_shd;
  logic [NUM_CH-1:0]            r_pend;
  logic [NUM_CH-1:0]            r_dclk;

  logic [NUM_CH-1:0]            w_wr;
  logic [NUM_CH-1:0]            w_off;
  logic [NUM_CH-1:0]            w_bnd;

  // Per-channel decode: config hit, channel switched off, toggle boundary.
  // An out-of-range cfg_ch matches no channel, so such writes fall away here.
  always_comb begin
    w_wr  = '0;
    w_off = '0;
    w_bnd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_wr[i]  = cfg_we && (cfg_ch == CH_W'(i));
      w_off[i] = (r_half_act[i] == '0);
      w_bnd[i] = !w_off[i] && en[i] && (r_cnt[i] == r_half_act[i] - CNT_W'(1));
    end
  end

  // Counter, output toggle, and shadow/active half-period handover per channel.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_dclk     <= '0;
      r_pend     <= '0;
      r_half_act <= {NUM_CH{DEF_HALF}};
      r_half_shd <= {NUM_CH{DEF_HALF}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_off[i]) begin
          // Channel off: park low and take any pending value without waiting.
          r_cnt[i]  <= '0;
          r_dclk[i] <= 1'b0;
          if (r_pend[i]) r_half_act[i] <= r_half_shd[i];
        end else if (en[i]) begin
          if (w_bnd[i]) begin
            r_cnt[i]  <= '0;
            r_dclk[i] <= ~r_dclk[i];
            if (r_pend[i]) r_half_act[i] <= r_half_shd[i];
          end else begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end
        end
        // A write wins over the clear: a value written on a boundary edge
        // waits for the following boundary while the older one is applied now.
        if (w_wr[i]) begin
          r_half_shd[i] <= cfg_half;
          r_pend[i]     <= 1'b1;
        end else if (w_off[i] || w_bnd[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  assign cfg_pending = r_pend;
  assign divided_clk = r_dclk;

`ifdef CLK_DIV_TICK_EN
  logic [NUM_CH-1:0] r_tick;

  // One-cycle pulse registered on the same edge as each divided_clk toggle.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) r_tick <= '0;
    else     r_tick <= w_bnd;
  end

  assign tick = r_tick;
`endif

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed testbench for clk_divider_multi (NUM_CH=3, CNT_W=8, DEFAULT_HALF=4).
module tb_clk_divider_multi;

  logic       clk_in = 1'b0;
  logic       rst;
  logic [2:0] en;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_half;
  logic [2:0] cfg_pending;
  logic [2:0] divided_clk;
`ifdef CLK_DIV_TICK_EN
  logic [2:0] tick;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  clk_divider_multi #(.NUM_CH(3), .CNT_W(8), .DEFAULT_HALF(4)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .en          (en),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_half    (cfg_half),
    .cfg_pending (cfg_pending),
    .divided_clk (divided_clk)
`ifdef CLK_DIV_TICK_EN
    ,
    .tick        (tick)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // Edge numbering below counts rising edges after reset release.
  task automatic test_reset;
    rst = 1'b1; en = 3'b000; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_half = 8'd0;
    step(2);
    n_cmp++; if (divided_clk !== 3'b000) begin n_mis++; $display("FAIL reset_dclk got=%b exp=000", divided_clk); end
    n_cmp++; if (cfg_pending !== 3'b000) begin n_mis++; $display("FAIL reset_pend got=%b exp=000", cfg_pending); end
    rst = 1'b0; en = 3'b111;
    step(3);
    n_cmp++; if (divided_clk !== 3'b000) begin n_mis++; $display("FAIL run_e3 got=%b exp=000", divided_clk); end
    step(1);
    n_cmp++; if (divided_clk !== 3'b111) begin n_mis++; $display("FAIL run_e4 got=%b exp=111", divided_clk); end
    step(3);
    n_cmp++; if (divided_clk !== 3'b111) begin n_mis++; $display("FAIL run_e7 got=%b exp=111", divided_clk); end
    step(1);
    n_cmp++; if (divided_clk !== 3'b000) begin n_mis++; $display("FAIL run_e8 got=%b exp=000", divided_clk); end
    n_cmp++; if (cfg_pending !== 3'b000) begin n_mis++; $display("FAIL run_pend got=%b exp=000", cfg_pending); end
  endtask

  task automatic test_reprogram;
    step(1);                                    // e9, cnt=1
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_half = 8'd2;
    step(1);                                    // e10
    cfg_we = 1'b0;
    n_cmp++; if (cfg_pending !== 3'b010) begin n_mis++; $display("FAIL reprog_pend_e10 got=%b exp=010", cfg_pending); end
    step(1);                                    // e11
    n_cmp++; if (cfg_pending !== 3'b010) begin n_mis++; $display("FAIL reprog_pend_e11 got=%b exp=010", cfg_pending); end
    n_cmp++; if (divided_clk !== 3'b000) begin n_mis++; $display("FAIL reprog_dclk_e11 got=%b exp=000", divided_clk); end
    step(1);                                    // e12 boundary, H1=2 applied
    n_cmp++; if (divided_clk !== 3'b111) begin n_mis++; $display("FAIL reprog_dclk_e12 got=%b exp=111", divided_clk); end
    n_cmp++; if (cfg_pending !== 3'b000) begin n_mis++; $display("FAIL reprog_pend_e12 got=%b exp=000", cfg_pending); end
    step(2);                                    // e14
    n_cmp++; if (divided_clk !== 3'b101) begin n_mis++; $display("FAIL reprog_dclk_e14 got=%b exp=101", divided_clk); end
    step(2);                                    // e16
    n_cmp++; if (divided_clk !== 3'b010) begin n_mis++; $display("FAIL reprog_dclk_e16 got=%b exp=010", divided_clk); end
  endtask

  task automatic test_hold;
    step(2);                                    // e18, ch0 cnt=2
    en = 3'b110;
    step(2);                                    // e20
    n_cmp++; if (divided_clk[0] !== 1'b0) begin n_mis++; $display("FAIL hold_e20 got=%b exp=0", divided_clk[0]); end
    step(3);                                    // e23
    n_cmp++; if (divided_clk[0] !== 1'b0) begin n_mis++; $display("FAIL hold_e23 got=%b exp=0", divided_clk[0]); end
    en = 3'b111;
    step(1);                                    // e24
    n_cmp++; if (divided_clk[0] !== 1'b0) begin n_mis++; $display("FAIL resume_e24 got=%b exp=0", divided_clk[0]); end
    step(1);                                    // e25
    n_cmp++; if (divided_clk[0] !== 1'b1) begin n_mis++; $display("FAIL resume_e25 got=%b exp=1", divided_clk[0]); end
  endtask

  task automatic test_half_zero;
    step(3);                                    // e28, ch2 cnt=0, dclk2=1
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_half = 8'd0;
    step(1);                                    // e29
    cfg_we = 1'b0;
    step(2);                                    // e31
    n_cmp++; if (cfg_pending !== 3'b100) begin n_mis++; $display("FAIL off_pend_e31 got=%b exp=100", cfg_pending); end
    n_cmp++; if (divided_clk[2] !== 1'b1) begin n_mis++; $display("FAIL off_dclk_e31 got=%b exp=1", divided_clk[2]); end
    step(1);                                    // e32 boundary, H2=0
    n_cmp++; if (divided_clk[2] !== 1'b0) begin n_mis++; $display("FAIL off_dclk_e32 got=%b exp=0", divided_clk[2]); end
    n_cmp++; if (cfg_pending !== 3'b000) begin n_mis++; $display("FAIL off_pend_e32 got=%b exp=000", cfg_pending); end
    step(4);                                    // e36
    n_cmp++; if (divided_clk[2] !== 1'b0) begin n_mis++; $display("FAIL off_dclk_e36 got=%b exp=0", divided_clk[2]); end
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_half = 8'd3;
    step(1);                                    // e37
    cfg_we = 1'b0;
    n_cmp++; if (cfg_pending !== 3'b100) begin n_mis++; $display("FAIL on_pend_e37 got=%b exp=100", cfg_pending); end
    step(1);                                    // e38, H2=3 applied
    n_cmp++; if (cfg_pending !== 3'b000) begin n_mis++; $display("FAIL on_pend_e38 got=%b exp=000", cfg_pending); end
    step(2);                                    // e40
    n_cmp++; if (divided_clk[2] !== 1'b0) begin n_mis++; $display("FAIL on_dclk_e40 got=%b exp=0", divided_clk[2]); end
    step(1);                                    // e41
    n_cmp++; if (divided_clk[2] !== 1'b1) begin n_mis++; $display("FAIL on_dclk_e41 got=%b exp=1", divided_clk[2]); end
    step(3);                                    // e44
    n_cmp++; if (divided_clk[2] !== 1'b0) begin n_mis++; $display("FAIL on_dclk_e44 got=%b exp=0", divided_clk[2]); end
  endtask

  task automatic test_bad_ch_and_reset;
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_half = 8'd1;
    step(1);                                    // e45
    cfg_we = 1'b0;
    n_cmp++; if (cfg_pending !== 3'b000) begin n_mis++; $display("FAIL badch_pend got=%b exp=000", cfg_pending); end
    n_cmp++; if (divided_clk !== 3'b010) begin n_mis++; $display("FAIL badch_dclk got=%b exp=010", divided_clk); end
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd5;
    step(1);                                    // e46
    cfg_we = 1'b0;
    n_cmp++; if (cfg_pending !== 3'b001) begin n_mis++; $display("FAIL prerst_pend got=%b exp=001", cfg_pending); end
    step(1);                                    // e47, dclk2 toggles to 1
    rst = 1'b1;
    #1;
    n_cmp++; if (divided_clk !== 3'b000) begin n_mis++; $display("FAIL arst_dclk got=%b exp=000", divided_clk); end
    n_cmp++; if (cfg_pending !== 3'b000) begin n_mis++; $display("FAIL arst_pend got=%b exp=000", cfg_pending); end
    step(1);
    rst = 1'b0; en = 3'b111;
    step(3);
    n_cmp++; if (divided_clk !== 3'b000) begin n_mis++; $display("FAIL rerun_e3 got=%b exp=000", divided_clk); end
    step(1);
    n_cmp++; if (divided_clk !== 3'b111) begin n_mis++; $display("FAIL rerun_e4 got=%b exp=111", divided_clk); end
  endtask

  task automatic test_back_to_back;
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd6;
    step(1);                                    // e5
    cfg_half = 8'd2;
    step(1);                                    // e6, overwrite
    cfg_we = 1'b0;
    n_cmp++; if (cfg_pending !== 3'b001) begin n_mis++; $display("FAIL b2b_pend_e6 got=%b exp=001", cfg_pending); end
    step(1);                                    // e7
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd1;
    step(1);                                    // e8 boundary + write
    cfg_we = 1'b0;
    n_cmp++; if (cfg_pending[0] !== 1'b1) begin n_mis++; $display("FAIL b2b_pend_e8 got=%b exp=1", cfg_pending[0]); end
    n_cmp++; if (divided_clk[0] !== 1'b0) begin n_mis++; $display("FAIL b2b_dclk_e8 got=%b exp=0", divided_clk[0]); end
    step(1);                                    // e9
    n_cmp++; if (divided_clk[0] !== 1'b0) begin n_mis++; $display("FAIL b2b_dclk_e9 got=%b exp=0", divided_clk[0]); end
    n_cmp++; if (cfg_pending[0] !== 1'b1) begin n_mis++; $display("FAIL b2b_pend_e9 got=%b exp=1", cfg_pending[0]); end
    step(1);                                    // e10, H0=1 applied
    n_cmp++; if (divided_clk[0] !== 1'b1) begin n_mis++; $display("FAIL b2b_dclk_e10 got=%b exp=1", divided_clk[0]); end
    n_cmp++; if (cfg_pending[0] !== 1'b0) begin n_mis++; $display("FAIL b2b_pend_e10 got=%b exp=0", cfg_pending[0]); end
    step(1);                                    // e11
    n_cmp++; if (divided_clk[0] !== 1'b0) begin n_mis++; $display("FAIL b2b_dclk_e11 got=%b exp=0", divided_clk[0]); end
    step(1);                                    // e12
    n_cmp++; if (divided_clk[0] !== 1'b1) begin n_mis++; $display("FAIL b2b_dclk_e12 got=%b exp=1", divided_clk[0]); end
  endtask

`ifdef CLK_DIV_TICK_EN
  task automatic test_tick;
    step(1);                                    // e13
    n_cmp++; if (tick !== 3'b001) begin n_mis++; $display("FAIL tick_e13 got=%b exp=001", tick); end
    step(2);                                    // e15
    n_cmp++; if (tick !== 3'b001) begin n_mis++; $display("FAIL tick_e15 got=%b exp=001", tick); end
    step(1);                                    // e16
    n_cmp++; if (tick !== 3'b111) begin n_mis++; $display("FAIL tick_e16 got=%b exp=111", tick); end
    en = 3'b000;
    step(1);                                    // e17
    n_cmp++; if (tick !== 3'b000) begin n_mis++; $display("FAIL tick_hold_e17 got=%b exp=000", tick); end
    step(2);                                    // e19
    n_cmp++; if (tick !== 3'b000) begin n_mis++; $display("FAIL tick_hold_e19 got=%b exp=000", tick); end
    n_cmp++; if (divided_clk !== 3'b001) begin n_mis++; $display("FAIL tick_hold_dclk got=%b exp=001", divided_clk); end
  endtask
`endif

  initial begin
    test_reset();
    test_reprogram();
    test_hold();
    test_half_zero();
    test_bad_ch_and_reset();
    test_back_to_back();
`ifdef CLK_DIV_TICK_EN
    test_tick();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
